// File: rtl/data_mem_responder.sv
// data_mem_responder: target side of a single-cycle core's data-memory port.
// Word RAM with combinational read / synchronous write, plus a 16-byte
// memory-mapped I/O window (LED, CYCLE, STORES, STATUS) and sticky error
// reporting for misaligned and unmapped stores.
// Optional feature macro: MEM_PERF_COUNTERS_EN enables the CYCLE and STORES
// counters; when undefined those offsets read 0 and no counter flops exist.
module data_mem_responder #(
    parameter int          MEM_WORDS = 64,
    parameter logic [31:0] IO_BASE   = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WriteEnableMem,
    input  logic [31:0] AddressDataMem,
    input  logic [31:0] WriteDataMem,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic        err_misaligned,
    output logic        err_range,
    output logic [31:0] err_addr
);

    localparam int AW = $clog2(MEM_WORDS);

    localparam logic [1:0] OFF_LED    = 2'd0;
    localparam logic [1:0] OFF_CYCLE  = 2'd1;
    localparam logic [1:0] OFF_STORES = 2'd2;
    localparam logic [1:0] OFF_STATUS = 2'd3;

    // State
    logic [31:0] mem_r [MEM_WORDS];
    logic [7:0]  leds_r;
    logic        err_mis_r;
    logic        err_range_r;
    logic [31:0] err_addr_r;
    logic [31:0] cycle_s;
    logic [31:0] stores_s;

    // Decode
    logic          aligned_s;
    logic          ram_hit_s;
    logic          io_hit_s;
    logic [1:0]    io_off_s;
    logic [AW-1:0] word_idx_s;

    // Write strobes and next-state for the error block
    logic        ram_we_s;
    logic        io_we_s;
    logic        led_we_s;
    logic        status_we_s;
    logic        set_mis_s;
    logic        set_range_s;
    logic        mis_nxt_s;
    logic        range_nxt_s;
    logic [31:0] err_addr_nxt_s;

    // Address decode: RAM by word index bound, IO by 16-byte window match.
    always_comb begin
        aligned_s  = (AddressDataMem[1:0] == 2'b00);
        ram_hit_s  = (AddressDataMem[31:2] < 30'(MEM_WORDS));
        io_hit_s   = (AddressDataMem[31:4] == IO_BASE[31:4]);
        io_off_s   = AddressDataMem[3:2];
        word_idx_s = AddressDataMem[AW+1:2];
    end

    // Store qualification: only aligned, mapped stores reach a target.
    always_comb begin
        ram_we_s    = WriteEnableMem & aligned_s & ram_hit_s;
        io_we_s     = WriteEnableMem & aligned_s & io_hit_s;
        led_we_s    = io_we_s & (io_off_s == OFF_LED);
        status_we_s = io_we_s & (io_off_s == OFF_STATUS);
        // Misaligned takes precedence, so a misaligned unmapped store only flags misalignment.
        set_mis_s   = WriteEnableMem & ~aligned_s;
        set_range_s = WriteEnableMem & aligned_s & ~ram_hit_s & ~io_hit_s;
    end

    // Sticky flags: a set wins over a W1C clear; err_addr records the first error only.
    always_comb begin
        mis_nxt_s      = set_mis_s   | (err_mis_r   & ~(status_we_s & WriteDataMem[0]));
        range_nxt_s    = set_range_s | (err_range_r & ~(status_we_s & WriteDataMem[1]));
        err_addr_nxt_s = err_addr_r;
        if ((set_mis_s | set_range_s) && !err_mis_r && !err_range_r) begin
            err_addr_nxt_s = AddressDataMem;
        end else if (status_we_s && !mis_nxt_s && !range_nxt_s) begin
            err_addr_nxt_s = 32'h0000_0000;
        end else begin
            err_addr_nxt_s = err_addr_r;
        end
    end

    // Word RAM: cleared by reset, written on accepted aligned RAM stores.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (ram_we_s) begin
            mem_r[word_idx_s] <= WriteDataMem;
        end
    end

    // LED register: only the low byte of the store data is kept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_r <= 8'h00;
        end else if (led_we_s) begin
            leds_r <= WriteDataMem[7:0];
        end
    end

    // Error status flags and first-error address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_mis_r   <= 1'b0;
            err_range_r <= 1'b0;
            err_addr_r  <= 32'h0000_0000;
        end else begin
            err_mis_r   <= mis_nxt_s;
            err_range_r <= range_nxt_s;
            err_addr_r  <= err_addr_nxt_s;
        end
    end

`ifdef MEM_PERF_COUNTERS_EN
    logic [31:0] cycle_r;
    logic [31:0] stores_r;

    // Free-running cycle counter, wraps naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_r <= 32'h0000_0000;
        end else begin
            cycle_r <= cycle_r + 32'd1;
        end
    end

    // Accepted RAM store counter, saturating at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stores_r <= 32'h0000_0000;
        end else if (ram_we_s && (stores_r != 32'hFFFF_FFFF)) begin
            stores_r <= stores_r + 32'd1;
        end
    end

    assign cycle_s  = cycle_r;
    assign stores_s = stores_r;
`else
    assign cycle_s  = 32'h0000_0000;
    assign stores_s = 32'h0000_0000;
`endif

    // Combinational load path; the low address bits are ignored on reads.
    always_comb begin
        ReadData = 32'hDEAD_BEEF;
        if (ram_hit_s) begin
            ReadData = mem_r[word_idx_s];
        end else if (io_hit_s) begin
            case (io_off_s)
                OFF_LED:    ReadData = {24'h00_0000, leds_r};
                OFF_CYCLE:  ReadData = cycle_s;
                OFF_STORES: ReadData = stores_s;
                OFF_STATUS: ReadData = {30'h0000_0000, err_range_r, err_mis_r};
                default:    ReadData = 32'hDEAD_BEEF;
            endcase
        end else begin
            ReadData = 32'hDEAD_BEEF;
        end
    end

    assign leds           = leds_r;
    assign err_misaligned = err_mis_r;
    assign err_range      = err_range_r;
    assign err_addr       = err_addr_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: stimulus pushes expected values,
// a negedge monitor pops and compares them against the selected DUT output.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        WriteEnableMem;
    logic [31:0] AddressDataMem;
    logic [31:0] WriteDataMem;
    logic [31:0] ReadData;
    logic [7:0]  leds;
    logic        err_misaligned;
    logic        err_range;
    logic [31:0] err_addr;

    localparam int SEL_RD    = 0;
    localparam int SEL_LEDS  = 1;
    localparam int SEL_MIS   = 2;
    localparam int SEL_RANGE = 3;
    localparam int SEL_EADDR = 4;

    typedef struct {
        string       nm;
        int          sel;
        logic [31:0] exp;
    } chk_t;

    chk_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cyc_m;

    data_mem_responder #(.MEM_WORDS(64), .IO_BASE(32'h0000_0100)) dut (
        .clk            (clk),
        .reset          (reset),
        .WriteEnableMem (WriteEnableMem),
        .AddressDataMem (AddressDataMem),
        .WriteDataMem   (WriteDataMem),
        .ReadData       (ReadData),
        .leds           (leds),
        .err_misaligned (err_misaligned),
        .err_range      (err_range),
        .err_addr       (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference cycle count: zero in reset, +1 on every clock otherwise.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc_m <= 32'h0;
        else       cyc_m <= cyc_m + 32'd1;
    end

    // Monitor: compare every queued expectation at the falling edge.
    always @(negedge clk) begin
        chk_t        e;
        logic [31:0] act;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_RD:    act = ReadData;
                SEL_LEDS:  act = {24'h0, leds};
                SEL_MIS:   act = {31'h0, err_misaligned};
                SEL_RANGE: act = {31'h0, err_range};
                default:   act = err_addr;
            endcase
            checks = checks + 1;
            if (act !== e.exp) begin
                failures = failures + 1;
                $display("FAIL %s: got %08h expected %08h", e.nm, act, e.exp);
            end
        end
    end

    task automatic expect_val(input string nm, input int sel, input logic [31:0] v);
        chk_t e;
        e.nm  = nm;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        WriteEnableMem = we;
        AddressDataMem = a;
        WriteDataMem   = d;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_errs(input string nm, input logic m, input logic r, input logic [31:0] a);
        expect_val({nm, "_mis"},   SEL_MIS,   {31'h0, m});
        expect_val({nm, "_range"}, SEL_RANGE, {31'h0, r});
        expect_val({nm, "_addr"},  SEL_EADDR, a);
    endtask

    initial begin
        int waited;
        reset = 1'b1;
        drive(1'b0, 32'h10, 32'h0);
        next();
        next();
        // Reset state
        expect_val("rst_rd", SEL_RD, 32'h0);
        expect_val("rst_leds", SEL_LEDS, 32'h0);
        expect_errs("rst", 1'b0, 1'b0, 32'h0);
        next();
        reset = 1'b0;
        next();

        // 1: RAM write, read-during-write sees old data
        drive(1'b1, 32'h10, 32'hCAFE_F00D);
        expect_val("rdw_old", SEL_RD, 32'h0);
        next();
        drive(1'b0, 32'h10, 32'h0);
        expect_val("ram_rd10", SEL_RD, 32'hCAFE_F00D);
        next();
        drive(1'b0, 32'h14, 32'h0);
        expect_val("ram_rd14", SEL_RD, 32'h0);
        next();
        drive(1'b0, 32'h108, 32'h0);
`ifdef MEM_PERF_COUNTERS_EN
        expect_val("stores1", SEL_RD, 32'h1);
`else
        expect_val("stores_off", SEL_RD, 32'h0);
`endif
        next();

        // 2: LED write, upper bits dropped
        drive(1'b1, 32'h100, 32'h0000_01A5);
        next();
        drive(1'b0, 32'h100, 32'h0);
        expect_val("leds", SEL_LEDS, 32'hA5);
        expect_val("led_rd", SEL_RD, 32'hA5);
        next();

        // 3: misaligned store, then unmapped store
        drive(1'b1, 32'h12, 32'h1111_1111);
        next();
        drive(1'b0, 32'h10, 32'h0);
        expect_val("mis_nowrite", SEL_RD, 32'hCAFE_F00D);
        expect_errs("mis", 1'b1, 1'b0, 32'h12);
        next();
        drive(1'b0, 32'h12, 32'h0);
        expect_val("mis_read", SEL_RD, 32'hCAFE_F00D);
        next();
        drive(1'b1, 32'h400, 32'h5);
        next();
        drive(1'b0, 32'h10C, 32'h0);
        expect_val("status3", SEL_RD, 32'h3);
        expect_errs("rng", 1'b1, 1'b1, 32'h12);
        next();

        // 4: W1C clear of each flag
        drive(1'b1, 32'h10C, 32'h1);
        next();
        drive(1'b0, 32'h10, 32'h0);
        expect_errs("clr1", 1'b0, 1'b1, 32'h12);
        next();
        drive(1'b1, 32'h10C, 32'h2);
        next();
        drive(1'b0, 32'h10, 32'h0);
        expect_errs("clr2", 1'b0, 1'b0, 32'h0);
        next();
        // Misaligned and unmapped: only misalignment flagged
        drive(1'b1, 32'h401, 32'h0);
        next();
        drive(1'b0, 32'h10, 32'h0);
        expect_errs("both", 1'b1, 1'b0, 32'h401);
        next();
        drive(1'b1, 32'h10C, 32'h3);
        next();
        // Store to read-only CYCLE: ignored without error
        drive(1'b1, 32'h104, 32'h0000_FFFF);
        next();
        drive(1'b0, 32'h10C, 32'h0);
        expect_val("ro_noerr", SEL_RD, 32'h0);
        expect_errs("ro", 1'b0, 1'b0, 32'h0);
        next();

        // 5: unmapped reads and cycle counter
        drive(1'b0, 32'h800, 32'h0);
        expect_val("unmapped", SEL_RD, 32'hDEAD_BEEF);
        next();
        drive(1'b0, 32'h110, 32'h0);
        expect_val("past_io", SEL_RD, 32'hDEAD_BEEF);
        next();
        drive(1'b1, 32'hFC, 32'h0000_0077);
        next();
        drive(1'b0, 32'hFC, 32'h0);
        expect_val("ram_last", SEL_RD, 32'h77);
        next();
        drive(1'b0, 32'h104, 32'h0);
`ifdef MEM_PERF_COUNTERS_EN
        expect_val("cycle_a", SEL_RD, cyc_m);
        next();
        expect_val("cycle_b", SEL_RD, cyc_m);
        next();
        drive(1'b0, 32'h108, 32'h0);
        expect_val("stores2", SEL_RD, 32'h2);
`else
        expect_val("cycle_a0", SEL_RD, 32'h0);
        next();
        expect_val("cycle_b0", SEL_RD, 32'h0);
`endif
        next();

        // 6: asynchronous reset between edges
        drive(1'b1, 32'h20, 32'hABCD_1234);
        next();
        drive(1'b1, 32'h22, 32'h0);
        expect_val("rd20", SEL_RD, 32'hABCD_1234);
        next();
        drive(1'b0, 32'h20, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        expect_val("arst_rd20", SEL_RD, 32'h0);
        expect_val("arst_leds", SEL_LEDS, 32'h0);
        expect_errs("arst", 1'b0, 1'b0, 32'h0);
        next();
        reset = 1'b0;
        next();
        expect_val("post_rd20", SEL_RD, 32'h0);
        next();

        waited = 0;
        while (sb.size() != 0 && waited < 10) begin
            next();
            waited++;
        end
        if (sb.size() != 0) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("FAIL drain: %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Data-memory responder: the target side of the processor's data-memory port (WriteEnableMem / AddressDataMem / WriteDataMem / ReadData).
- Word RAM: combinational read, synchronous write, so a single-cycle core completes loads in the same cycle.
- Small memory-mapped I/O window: LED register, cycle counter, store counter, sticky error status.
- Sits between the core and board I/O.

Parameters:
MEM_WORDS, 64, number of 32-bit RAM words (power of two, 16..1024); RAM occupies byte addresses 0 .. MEM_WORDS*4-1
IO_BASE, 32'h0000_0100, base byte address of the 16-byte I/O window (16-byte aligned, must not overlap RAM)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
WriteEnableMem  input  1  store strobe from core, sampled at rising clk
AddressDataMem  input  32  byte address from core
WriteDataMem  input  32  store data from core
ReadData  output  32  load data to core, combinational from address
leds  output  8  LED register contents
err_misaligned  output  1  sticky: access with AddressDataMem[1:0]!=0
err_range  output  1  sticky: access to unmapped address
err_addr  output  32  address of first error since last clear

Behaviour:
Reset:
- Async, active-high; all RAM words = 0, leds = 0, counters = 0, err_* = 0, err_addr = 0.
- ReadData is combinational, so it reads 0 for RAM/LED/counter addresses during reset.

Decode uses word address AddressDataMem[31:2]:
- RAM hit: address < MEM_WORDS*4.
- IO hit: AddressDataMem[31:4] == IO_BASE[31:4]. Offsets:
  - 0x0 LED: RW, bits[7:0]; upper bits read 0, ignored on write.
  - 0x4 CYCLE: RO, 32-bit free-running, +1 every clk, wraps FFFFFFFF -> 0.
  - 0x8 STORES: RO, +1 per accepted RAM write, saturates at FFFFFFFF.
  - 0xC STATUS: bit0 = err_misaligned, bit1 = err_range, others 0. Writing 1 to a bit clears it (W1C); writing 0 leaves it unchanged.
- Writes to RO offsets are ignored without error.
- Anything else is unmapped.

Reads:
- Combinational, zero latency.
- Unmapped: ReadData = 32'hDEADBEEF.
- Misaligned: low two address bits ignored, word returned, error not raised. The core cannot signal read vs. no-access, so reads never set errors.

Writes (rising clk with WriteEnableMem=1):
- Aligned RAM or IO: target updated; ReadData shows new value after the edge.
- Read-during-write to the same address returns old data before the edge.
- Misaligned: write suppressed, err_misaligned <= 1.
- Unmapped aligned: write suppressed, err_range <= 1.
- Misaligned and unmapped: only err_misaligned set.
- err_addr captured only if both sticky flags were 0 before the edge; cleared to 0 when a STATUS write clears both flags.

Simultaneous events:
- Set beats W1C clear in the same cycle. This cannot occur through STATUS itself, since a STATUS write is aligned and mapped.
- STORES increments only on accepted RAM writes, never IO writes.
- CYCLE counts every cycle regardless of stores.

Reset mid-operation: asynchronous assertion immediately forces all state to reset values; a write on the same edge reset deasserts is ignored.

Optional Feature:
MEM_PERF_COUNTERS_EN
- Defined: CYCLE and STORES counters implemented as above.
- Undefined: both counters absent (no flops), offsets 0x4/0x8 read 0, writes to them ignored. All other behaviour is identical.

Test Plan:
1. Reset, then write 32'hCAFEF00D to 0x10 (WE 1 cycle), read 0x10 -> ReadData=CAFEF00D; read 0x14 -> 0; STORES=1.
2. Write 32'h000001A5 to IO_BASE+0 -> leds=8'hA5; read IO_BASE+0 -> 32'h000000A5.
3. Write to 0x12 (misaligned) -> RAM word 0x10 unchanged, err_misaligned=1, err_addr=0x12. Then write 0x400 (unmapped, MEM_WORDS=64) -> err_range=1, err_addr stays 0x12.
4. Write 32'h1 to IO_BASE+0xC -> err_misaligned=0, err_range=1, err_addr=0x12. Write 32'h2 -> both 0, err_addr=0.
5. Read unmapped 0x800 -> 32'hDEADBEEF. Read IO_BASE+4 on two consecutive cycles -> values differ by 1 (feature on); always 0 (feature off).
6. Assert reset asynchronously between edges after writing 0x20 -> immediately leds=0, err_*=0; read 0x20 -> 0.
